// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - Moore main control FSM for the multi-cycle MIPS datapath (optional bne via CTRL_BNE_EN)
module multicycle_control #(
  parameter int MEM_LATENCY = 1,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  output logic             pcwrite,
  output logic             pcwritecond,
  output logic             iord,
  output logic             memread,
  output logic             memwrite,
  output logic             irwrite,
  output logic             regwrite,
  output logic             alusrca,
  output logic             bne,
  output logic [1:0]       regdst,
  output logic [1:0]       memtoreg,
  output logic [1:0]       alusrcb,
  output logic [1:0]       aluop,
  output logic [1:0]       pcsource,
  output logic             illegal,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_JAL    = 4'd10,
    S_JR     = 4'd11
  } state_t;

  localparam int WW = $clog2(MEM_LATENCY + 1);
  localparam logic [WW-1:0] WLAST = WW'(MEM_LATENCY - 1);

  state_t          cur;
  state_t          nxt;
  logic [WW-1:0]   wcnt;
  logic            wait_last;
  logic            is_lw_q;
  logic            dec_ill;
  logic            retire;
`ifdef CTRL_BNE_EN
  logic            dec_bne;
  logic            bne_q;
`endif

  assign wait_last = (wcnt == WLAST);

  // FETCH holds do not retire anything; only a return to FETCH from a later state does
  assign retire = (nxt == S_FETCH) && (cur != S_FETCH) && !dec_ill;

  // next-state decode; op/funct matter only in DECODE
  always_comb begin
    nxt     = S_FETCH;
    dec_ill = 1'b0;
`ifdef CTRL_BNE_EN
    dec_bne = 1'b0;
`endif
    case (cur)
      S_FETCH:  nxt = wait_last ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          6'b000000: nxt = (funct == 6'b001000) ? S_JR : S_EXEC;
          6'b100011,
          6'b101011: nxt = S_MEMADR;
          6'b000100: nxt = S_BRANCH;
          6'b000010: nxt = S_JUMP;
          6'b000011: nxt = S_JAL;
`ifdef CTRL_BNE_EN
          6'b000101: begin
            nxt     = S_BRANCH;
            dec_bne = 1'b1;
          end
`endif
          default: begin
            nxt     = S_FETCH;
            dec_ill = 1'b1;
          end
        endcase
      end
      S_MEMADR: nxt = is_lw_q ? S_MEMRD : S_MEMWR;
      S_MEMRD:  nxt = wait_last ? S_MEMWB : S_MEMRD;
      S_MEMWR:  nxt = wait_last ? S_FETCH : S_MEMWR;
      S_EXEC:   nxt = S_RWB;
      default:  nxt = S_FETCH;
    endcase
  end

  // state, wait counter, latched decode flags and retired-instruction counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur         <= S_FETCH;
      wcnt        <= '0;
      is_lw_q     <= 1'b0;
      instr_count <= '0;
`ifdef CTRL_BNE_EN
      bne_q       <= 1'b0;
`endif
    end else begin
      cur <= nxt;
      if (nxt != cur) wcnt <= '0;
      else            wcnt <= wcnt + WW'(1);
      if (cur == S_DECODE) begin
        is_lw_q <= (op == 6'b100011);
`ifdef CTRL_BNE_EN
        bne_q   <= dec_bne;
`endif
      end
      if (retire) instr_count <= instr_count + CNT_W'(1);
    end
  end

  // Moore output decode from the current state and wait counter
  always_comb begin
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    iord        = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    irwrite     = 1'b0;
    regwrite    = 1'b0;
    alusrca     = 1'b0;
    bne         = 1'b0;
    regdst      = 2'b00;
    memtoreg    = 2'b00;
    alusrcb     = 2'b00;
    aluop       = 2'b00;
    pcsource    = 2'b00;
    case (cur)
      S_FETCH: begin
        memread = 1'b1;
        alusrcb = 2'b01;
        irwrite = wait_last;
        pcwrite = wait_last;
      end
      S_DECODE: alusrcb = 2'b11;
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD: begin
        memread = 1'b1;
        iord    = 1'b1;
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 2'b01;
      end
      S_MEMWR: begin
        memwrite = 1'b1;
        iord     = 1'b1;
      end
      S_EXEC: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      S_RWB: begin
        regwrite = 1'b1;
        regdst   = 2'b01;
      end
      S_BRANCH: begin
        alusrca     = 1'b1;
        aluop       = 2'b01;
        pcwritecond = 1'b1;
        pcsource    = 2'b01;
`ifdef CTRL_BNE_EN
        bne         = bne_q;
`endif
      end
      S_JUMP: begin
        pcwrite  = 1'b1;
        pcsource = 2'b10;
      end
      S_JAL: begin
        pcwrite  = 1'b1;
        pcsource = 2'b10;
        regwrite = 1'b1;
        regdst   = 2'b10;
        memtoreg = 2'b10;
      end
      S_JR: begin
        pcwrite  = 1'b1;
        pcsource = 2'b11;
      end
      default: ;
    endcase
  end

  assign illegal = dec_ill;
  assign state   = cur;

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Moore-style main control FSM for the multi-cycle MIPS datapath; it replaces the single-cycle combinational decoder. It sequences fetch, decode, execute, memory and write-back for R-type, jr, lw, sw, beq, j and jal. It supports a parameterised memory latency and counts retired instructions. It sits between the instruction register (op/funct fields) and every datapath mux and write enable.

## Interface
- `MEM_LATENCY`, 1: cycles each memory-access state is held (≥1).
- `CNT_W`, 32: width of the retired-instruction counter.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `op` in 6: IR[31:26].
- `funct` in 6: IR[5:0].
- `pcwrite`, `pcwritecond`, `iord`, `memread`, `memwrite`, `irwrite`, `regwrite`, `alusrca` out 1: datapath enables and selects.
- `bne` out 1: inverts the zero sense for `pcwritecond` (the datapath uses `pcwritecond & (zero ^ bne)`).
- `regdst` out 2: write register. 00 = rt, 01 = rd, 10 = $31.
- `memtoreg` out 2: write data. 00 = ALUOut, 01 = MDR, 10 = PC.
- `alusrcb` out 2: ALU B operand. 00 = B, 01 = 4, 10 = signext, 11 = signext<<2.
- `aluop` out 2: 00 = add, 01 = sub, 10 = use funct.
- `pcsource` out 2: 00 = ALU, 01 = ALUOut, 10 = jump target, 11 = register A.
- `illegal` out 1: one-cycle pulse on an undecodable opcode.
- `state` out 4: current state, for debug.
- `instr_count` out CNT_W: number of retired instructions.

## Operation
- States: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, JAL=10, JR=11. Codes 12–15 are unreachable and recover to FETCH.
- Outputs are decoded from the state (and the wait counter) only. Every output not listed for a state is 0.
- FETCH: memread=1, alusrcb=01.
  - On its last cycle only: irwrite=1, pcwrite=1.
- DECODE: alusrcb=11.
  - Next state by opcode:
    - op 000000 with funct 001000 → JR.
    - op 000000 otherwise → EXEC.
    - 100011 and 101011 → MEMADR.
    - 000100 → BRANCH.
    - 000010 → JUMP.
    - 000011 → JAL.
    - Anything else → FETCH, with `illegal`=1 for this cycle.
- MEMADR: alusrca=1, alusrcb=10. Next state is MEMRD for lw, MEMWR for sw.
- MEMRD: memread=1, iord=1. Next state is MEMWB.
- MEMWB: regwrite=1, memtoreg=01, regdst=00.
- MEMWR: memwrite=1, iord=1.
- EXEC: alusrca=1, aluop=10. Next state is RWB.
- RWB: regwrite=1, regdst=01, memtoreg=00.
- BRANCH: alusrca=1, aluop=01, pcwritecond=1, pcsource=01.
- JUMP: pcwrite=1, pcsource=10.
- JAL: pcwrite=1, pcsource=10, regwrite=1, regdst=10, memtoreg=10. The PC read here already holds PC+4.
- JR: pcwrite=1, pcsource=11.
- Terminal states return to FETCH: MEMWB, MEMWR (after its last cycle), RWB, BRANCH, JUMP, JAL, JR.
- Wait counter:
  - FETCH, MEMRD and MEMWR each last MEM_LATENCY cycles.
  - An internal counter of width $clog2(MEM_LATENCY+1) is zeroed on state entry and advances each cycle.
  - The state exits when the count equals MEM_LATENCY−1.
  - memread/memwrite/iord stay constant across the whole hold.
- `instr_count`:
  - Increments by 1 in each cycle whose next state is FETCH, except the illegal-opcode return.
  - Wraps modulo 2^CNT_W.

## Timing
- Reset: state=FETCH, wait counter=0, instr_count=0, illegal=0.
  - Outputs then equal FETCH cycle 0: memread=1, alusrcb=01, all others 0.
  - With MEM_LATENCY=1, irwrite=pcwrite=1 during reset.
- Reset asserted mid-instruction aborts it immediately, with no partial write enables after the asserting edge.
- Let L = MEM_LATENCY. Cycles per instruction:
  - R-type: L+3
  - lw: 2L+3
  - sw: 2L+2
  - beq, j, jal, jr: L+2
- `op` and `funct` are sampled only in DECODE. The IR is stable from the end of FETCH onward.

## Configuration
- `CTRL_BNE_EN` defined:
  - op 000101 decodes from DECODE → BRANCH.
  - BRANCH then drives bne=1 for that instruction; the instruction retires normally.
- `CTRL_BNE_EN` undefined:
  - 000101 is illegal: DECODE → FETCH with the `illegal` pulse.
  - `bne` is tied to 0.

## Test plan
- L=1, reset released, add (op 0, funct 100000) → states 0,1,6,7,0.
  - regwrite=1 and regdst=01 in state 7.
  - instr_count=1 after 4 cycles.
- L=3, lw (op 100011) → FETCH held 3 cycles with irwrite only on the 3rd; MEMRD held 3 cycles with memread=iord=1.
  - Total 9 cycles; MEMWB has memtoreg=01.
- L=1, jal (op 000011) then jr (op 0, funct 001000) → JAL drives regdst=10, memtoreg=10, pcsource=10; JR drives pcsource=11, pcwrite=1.
  - 3 cycles each.
- op 111111 → `illegal` high for exactly 1 cycle in DECODE, then FETCH.
  - instr_count unchanged.
- With and without `CTRL_BNE_EN`, op 000101:
  - Defined: BRANCH with bne=1, pcwritecond=1, aluop=01.
  - Undefined: illegal pulse, bne stays 0.
- L=2, rst_n pulled low during MEMWR cycle 1 → memwrite drops asynchronously, state=0, instr_count=0; the next fetch proceeds normally.
